instr_encoder: RTL and testbench
================================

# instr_encoder

Y86-64 instruction encoder and instruction-memory writer: accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and serialises it into the byte-wide instruction memory, one byte per cycle, at an auto-incrementing write pointer. It is the write-side counterpart of the fetch stage. The byte layout it produces is exactly what fetch reassembles. It is used by the testbench/loader path to build programs in instruction memory without hand-written binary files.

## Interface
Parameters:
- ADDR_W, 64, width of write pointer and mem_addr.
- MEM_BYTES, 22, instruction-memory depth in bytes; highest writable address is MEM_BYTES-1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- addr_load  input  1  load write pointer from addr_in; honoured only in IDLE.
- addr_in  input  ADDR_W  new write-pointer value.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder can accept; combinational, equals (state==IDLE && !addr_load).
- icode, ifun, rA, rB  input  4 each  instruction fields.
- valC  input  64  constant/destination word.
- mem_we  output  1  byte write strobe.
- mem_addr  output  ADDR_W  byte address.
- mem_wdata  output  8  byte data.
- instr_done  output  1  one-cycle pulse coincident with last byte write.
- instr_len  output  4  length of the last completed instruction (1, 2, 9 or 10); holds until the next completion.
- enc_error  output  1  one-cycle pulse on rejected instruction.
- wptr  output  ADDR_W  current write pointer (address of next byte).

## Operation
- Length by icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; C..F invalid.
- Byte 0 = {icode, ifun}. For len 2/10: byte 1 = {rA, rB}. For len 10: bytes 2..9 = valC. For len 9: bytes 1..8 = valC.
- valC is emitted most-significant byte first: lowest address holds valC[63:56]. This matches fetch, which concatenates bytes in address order.
- Accept = in_valid && in_ready. All fields are latched on accept. Later input changes have no effect.
- FSM states:
  - IDLE: on addr_load, wptr <= addr_in. On accept with a valid icode and wptr+len <= MEM_BYTES, go to EMIT with byte index 0. On accept with an invalid icode or an overflow, go to ERR.
  - EMIT: mem_we=1, mem_addr=wptr, mem_wdata=byte[idx], then wptr++ and idx++. When idx==len-1: pulse instr_done, update instr_len, return to IDLE.
  - ERR: enc_error=1 for one cycle, no write, wptr unchanged, return to IDLE.
- The overflow check is computed at ADDR_W+1 bits so that wptr near 2^ADDR_W cannot wrap. Landing exactly on MEM_BYTES is legal.
- addr_load in EMIT/ERR is ignored. addr_load in IDLE wins over in_valid, because in_ready is low in that cycle.
- ifun, rA and rB are encoded verbatim with no validity checks. rA/rB bytes for len-1/len-9 instructions are not emitted.

## Timing
- Accept at edge N. First byte is written in cycle N+1 (mem_we high after edge N). The last byte is written in cycle N+len.
- Occupancy is len+1 cycles per instruction (IDLE accept cycle + len EMIT cycles). An error costs 2 cycles.
- All outputs are registered except in_ready.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, instr_done=0, instr_len=0, enc_error=0, wptr=0, state=IDLE, so in_ready=1 while rst_n is low.
- Reset mid-EMIT aborts immediately: mem_we drops asynchronously, and bytes already written stay in memory. Accept is possible on the first edge after rst_n rises.

## Structure
- Shared package y86_pkg, also used by fetch:
  - icode localparams: HALT=0, NOP=1, CMOVXX=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
  - Function instr_len(icode), returning 0 for invalid codes.
- Local state enum: IDLE/EMIT/ERR.
- Single module. Byte selection is a combinational mux on idx within the module; no sub-module.

## Test plan
- Reset, addr_load 0, then irmovq (3,0,F,2,valC=0x100): writes at addr 0..9 with data 30,F2,00,00,00,00,00,00,01,00; instr_done in 10th write cycle; instr_len=10; wptr=10.
- halt then nop back-to-back from addr 0: 0x00@0, 0x10@1. Each accept is spaced 2 cycles apart; wptr=2.
- addr_load 5, then call valC=0x11: 9 writes to addr 5..13 with data 80,00×7,11; instr_len=9.
- icode=0xC: enc_error pulses one cycle, mem_we stays 0, wptr unchanged, in_ready back high 2 cycles after accept.
- addr_load 15 plus irmovq: error (25>22). addr_load 12 plus irmovq: exact fit, writes addr 12..21, wptr=22.
- Assert rst_n low after 3 bytes of an irmovq: mem_we=0 immediately, wptr=0. After release, a nop encodes at addr 0.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 opcode constants and the opcode-to-length table,
// shared by the fetch stage and the instruction encoder.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    // Encoded length in bytes; 0 flags an invalid icode.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            HALT, NOP, RET:           return 4'd1;
            CMOVXX, OPQ, PUSHQ, POPQ: return 4'd2;
            JXX, CALL:                return 4'd9;
            IRMOVQ, RMMOVQ, MRMOVQ:   return 4'd10;
            default:                  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: instruction handshake plus byte-wide instruction-memory
// write port; master drives instructions, slave is the encoder.
interface instr_encoder_if #(parameter int ADDR_W = 64);

    logic              addr_load;
    logic [ADDR_W-1:0] addr_in;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [63:0]       valC;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              instr_done;
    logic [3:0]        instr_len;
    logic              enc_error;
    logic [ADDR_W-1:0] wptr;

    modport master (
        output addr_load, addr_in, in_valid, icode, ifun, rA, rB, valC,
        input  in_ready, mem_we, mem_addr, mem_wdata, instr_done, instr_len, enc_error, wptr
    );

    modport slave (
        input  addr_load, addr_in, in_valid, icode, ifun, rA, rB, valC,
        output in_ready, mem_we, mem_addr, mem_wdata, instr_done, instr_len, enc_error, wptr
    );

endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: serialises one Y86-64 instruction per handshake into
// byte-wide instruction memory at an auto-incrementing write pointer.
module instr_encoder
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 22
) (
    input logic             clk,
    input logic             rst_n,
    instr_encoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EMIT, ERR} state_t;

    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] MEM_LIM = AW1'(MEM_BYTES);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d, len_q, len_d;
    logic [7:0]        regs_q, regs_d;
    logic [63:0]       valc_q, valc_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              instr_done_q, instr_done_d;
    logic [3:0]        instr_len_q, instr_len_d;
    logic              enc_error_q, enc_error_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;

    logic       accept, ok, has_regs;
    logic [3:0] len_in;
    logic [2:0] c_idx;
    logic [7:0] emit_byte;

    assign bus.in_ready   = state_q == IDLE && !bus.addr_load;
    assign accept         = bus.in_valid && bus.in_ready;
    assign len_in         = instr_len(bus.icode);
    // Extra MSB keeps wptr+len from wrapping near the top of the address space.
    assign ok             = len_in != 4'd0 && ({1'b0, wptr_q} + AW1'(len_in)) <= MEM_LIM;

    assign has_regs       = len_q == 4'd2 || len_q == 4'd10;
    assign c_idx          = 3'(idx_q - 4'd1 - {3'd0, has_regs});
    assign emit_byte      = has_regs && idx_q == 4'd1 ? regs_q : 8'(valc_q >> {~c_idx, 3'b000});

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.instr_done = instr_done_q;
    assign bus.instr_len  = instr_len_q;
    assign bus.enc_error  = enc_error_q;
    assign bus.wptr       = wptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (accept ? (ok ? EMIT : ERR) : IDLE) :
                  state_q == EMIT && idx_q != len_q ? EMIT : IDLE;
    end

    // idx_q is the index of the next byte to emit; byte 0 comes straight from the inputs.
    always_comb begin
        mem_we_d     = state_d == EMIT;
        mem_addr_d   = mem_we_d ? wptr_q : mem_addr_q;
        mem_wdata_d  = !mem_we_d ? mem_wdata_q : state_q == IDLE ? {bus.icode, bus.ifun} : emit_byte;
        instr_done_d = mem_we_d && (state_q == IDLE ? len_in == 4'd1 : idx_q == len_q - 4'd1);
        instr_len_d  = !instr_done_d ? instr_len_q : state_q == IDLE ? len_in : len_q;
        enc_error_d  = state_d == ERR;
        wptr_d       = state_q == IDLE && bus.addr_load ? bus.addr_in :
                       mem_we_d ? wptr_q + ADDR_W'(1) : wptr_q;
        idx_d        = state_q == IDLE ? 4'd1 : idx_q + 4'd1;
        len_d        = accept ? len_in : len_q;
        regs_d       = accept ? {bus.rA, bus.rB} : regs_q;
        valc_d       = accept ? bus.valC : valc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            instr_done_q <= 1'b0;
            instr_len_q  <= '0;
            enc_error_q  <= 1'b0;
            wptr_q       <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            regs_q       <= '0;
            valc_q       <= '0;
        end else begin
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            instr_done_q <= instr_done_d;
            instr_len_q  <= instr_len_d;
            enc_error_q  <= enc_error_d;
            wptr_q       <= wptr_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            regs_q       <= regs_d;
            valc_q       <= valc_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench; each accepted instruction pushes its
// expected byte writes, a negedge monitor pops and compares every write.
module tb_instr_encoder;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
        logic        last;
        logic [3:0]  len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    logic [63:0] wptr_m = '0;
    exp_t        q[$];

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(64)) bus ();

    instr_encoder #(.ADDR_W(64), .MEM_BYTES(22)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_write addr=%0h data=%02h", bus.mem_addr, bus.mem_wdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data || bus.instr_done !== e.last) begin
                    miscompares++;
                    $display("FAIL byte_write got addr=%0h data=%02h done=%b want addr=%0h data=%02h done=%b",
                             bus.mem_addr, bus.mem_wdata, bus.instr_done, e.addr, e.data, e.last);
                end
                if (e.last) begin
                    done_cyc = cyc;
                    vectors++;
                    if (bus.instr_len !== e.len) begin
                        miscompares++;
                        $display("FAIL instr_len_at_done got %0d want %0d", bus.instr_len, e.len);
                    end
                end
            end
        end else if (rst_n && bus.instr_done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_without_write got instr_done=1 want 0");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ref_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd0;
        endcase
    endfunction

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc);
        logic [3:0] n;
        logic [7:0] b [10];
        int k;
        int t;
        n = ref_len(ic);
        if (n != 0 && wptr_m + 64'(n) <= 64'd22) begin
            b[0] = {ic, fn};
            k = 1;
            if (n == 4'd2 || n == 4'd10) begin
                b[1] = {ra, rb};
                k = 2;
            end
            if (n >= 4'd9)
                for (int j = 7; j >= 0; j--) begin
                    b[k] = 8'(vc >> (8 * j));
                    k++;
                end
            for (int i = 0; i < int'(n); i++)
                q.push_back('{wptr_m + 64'(i), b[i], i == int'(n) - 1, n});
            wptr_m += 64'(n);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.icode = ic;
        bus.ifun = fn;
        bus.rA = ra;
        bus.rB = rb;
        bus.valC = vc;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.icode = 4'($urandom);
        bus.ifun = 4'($urandom);
        bus.rA = 4'($urandom);
        bus.rB = 4'($urandom);
        bus.valC = {$urandom, $urandom};
    endtask

    task automatic addr_load_to(input logic [63:0] a);
        @(negedge clk);
        bus.addr_load = 1'b1;
        bus.addr_in = a;
        bus.in_valid = 1'b1;
        bus.icode = 4'h1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_during_load got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        bus.addr_load = 1'b0;
        bus.in_valid = 1'b0;
        wptr_m = a;
        vectors++;
        if (bus.wptr !== a) begin
            miscompares++;
            $display("FAIL addr_load_wptr got %0h want %0h", bus.wptr, a);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!(bus.in_ready && q.size() == 0) && t < 40);
        if (!(bus.in_ready && q.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout got ready=%b pending=%0d want ready=1 pending=0", bus.in_ready, q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.instr_done, bus.instr_len, bus.enc_error, bus.wptr}
            !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got we=%b addr=%0h data=%0h done=%b len=%0d err=%b wptr=%0h want all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.instr_done, bus.instr_len, bus.enc_error, bus.wptr);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_irmovq();
        addr_load_to(64'd0);
        send(4'h3, 4'h0, 4'hF, 4'h2, 64'h100);
        vectors++;
        if (bus.mem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL first_write_latency got mem_we=%b want 1", bus.mem_we);
        end
        wait_idle();
        vectors++;
        if (done_cyc - acc_cyc !== 9) begin
            miscompares++;
            $display("FAIL irmovq_done_cycle got %0d want 9", done_cyc - acc_cyc);
        end
        vectors++;
        if (bus.instr_len !== 4'd10 || bus.wptr !== 64'd10) begin
            miscompares++;
            $display("FAIL irmovq_final got len=%0d wptr=%0h want len=10 wptr=a", bus.instr_len, bus.wptr);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        addr_load_to(64'd0);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
        t1 = acc_cyc;
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        vectors++;
        if (acc_cyc - t1 !== 2) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d want 2", acc_cyc - t1);
        end
        wait_idle();
        vectors++;
        if (bus.wptr !== 64'd2 || bus.instr_len !== 4'd1) begin
            miscompares++;
            $display("FAIL b2b_final got wptr=%0h len=%0d want wptr=2 len=1", bus.wptr, bus.instr_len);
        end
    endtask

    task automatic test_call();
        addr_load_to(64'd5);
        send(4'h8, 4'h0, 4'h0, 4'h0, 64'h11);
        wait_idle();
        vectors++;
        if (done_cyc - acc_cyc !== 8) begin
            miscompares++;
            $display("FAIL call_done_cycle got %0d want 8", done_cyc - acc_cyc);
        end
        vectors++;
        if (bus.instr_len !== 4'd9 || bus.wptr !== 64'd14) begin
            miscompares++;
            $display("FAIL call_final got len=%0d wptr=%0h want len=9 wptr=e", bus.instr_len, bus.wptr);
        end
    endtask

    task automatic test_invalid();
        send(4'hC, 4'h5, 4'h1, 4'h2, 64'hFFFF);
        vectors++;
        if (bus.enc_error !== 1'b1 || bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_err_cycle got err=%b we=%b rdy=%b want err=1 we=0 rdy=0",
                     bus.enc_error, bus.mem_we, bus.in_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.enc_error !== 1'b0 || bus.in_ready !== 1'b1 || bus.wptr !== 64'd14) begin
            miscompares++;
            $display("FAIL invalid_after got err=%b rdy=%b wptr=%0h want err=0 rdy=1 wptr=e",
                     bus.enc_error, bus.in_ready, bus.wptr);
        end
    endtask

    task automatic test_overflow();
        addr_load_to(64'd15);
        send(4'h3, 4'h0, 4'hF, 4'h1, 64'h55);
        vectors++;
        if (bus.enc_error !== 1'b1 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_err got err=%b we=%b want err=1 we=0", bus.enc_error, bus.mem_we);
        end
        wait_idle();
        vectors++;
        if (bus.wptr !== 64'd15) begin
            miscompares++;
            $display("FAIL overflow_wptr got %0h want f", bus.wptr);
        end
        addr_load_to(64'd12);
        send(4'h3, 4'h0, 4'hF, 4'h4, 64'h0123_4567_89AB_CDEF);
        wait_idle();
        vectors++;
        if (bus.wptr !== 64'd22 || bus.instr_len !== 4'd10) begin
            miscompares++;
            $display("FAIL exact_fit got wptr=%0h len=%0d want wptr=16 len=10", bus.wptr, bus.instr_len);
        end
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
        vectors++;
        if (bus.enc_error !== 1'b1 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL full_mem_err got err=%b we=%b want err=1 we=0", bus.enc_error, bus.mem_we);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int t;
        addr_load_to(64'd0);
        send(4'h3, 4'h0, 4'hF, 4'h3, 64'hDEAD_BEEF_0000_0001);
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (q.size() > 7 && t < 20);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.wptr !== 64'd0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset got we=%b wptr=%0h rdy=%b want we=0 wptr=0 rdy=1",
                     bus.mem_we, bus.wptr, bus.in_ready);
        end
        q.delete();
        wptr_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        wait_idle();
        vectors++;
        if (bus.wptr !== 64'd1 || bus.instr_len !== 4'd1) begin
            miscompares++;
            $display("FAIL post_reset_nop got wptr=%0h len=%0d want wptr=1 len=1", bus.wptr, bus.instr_len);
        end
    endtask

    initial begin
        bus.addr_load = 1'b0;
        bus.addr_in = '0;
        bus.in_valid = 1'b0;
        bus.icode = '0;
        bus.ifun = '0;
        bus.rA = '0;
        bus.rB = '0;
        bus.valC = '0;
        test_reset();
        test_irmovq();
        test_back_to_back();
        test_call();
        test_invalid();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
